// File: rtl/bcd_stopwatch_ctrl_if.sv
// Bus between the stopwatch controller and its environment: command pulses
// from the debouncers, the live counter value, and the enable/clear/display
// signals the controller produces.
//
// Signalling: there is no valid/ready pair on this bus. Every cmd_* input is
// a single-cycle pulse that is consumed at the rising edge that samples it;
// nothing is back-pressured. cnt_en and cnt_clr are likewise single-cycle
// qualifiers the counter acts on at the next rising edge.
interface bcd_stopwatch_ctrl_if #(
    parameter int PARAM_DIGITS = 4
);
    logic                      cmd_start_stop;
    logic                      cmd_lap;
    logic                      cmd_clear;
    logic [4*PARAM_DIGITS-1:0] cnt_data;
    logic                      cnt_en;
    logic                      cnt_clr;
    logic [4*PARAM_DIGITS-1:0] disp_data;
    logic [1:0]                state;
    logic                      ovf;

    // Environment side: issues commands and returns the counter value.
    modport master (
        output cmd_start_stop, cmd_lap, cmd_clear, cnt_data,
        input  cnt_en, cnt_clr, disp_data, state, ovf
    );

    // Controller side.
    modport slave (
        input  cmd_start_stop, cmd_lap, cmd_clear, cnt_data,
        output cnt_en, cnt_clr, disp_data, state, ovf
    );
endinterface

// File: rtl/bcd_stopwatch_ctrl.sv
// Stopwatch sequencing controller for an N-digit BCD counter.
// Turns start/stop, lap and clear pulses into a prescaled count enable and a
// registered counter clear, muxes a frozen lap value onto the display and
// flags overflow when the counter is at its all-max value.
//
// Optional build macro: BCD_STOPWATCH_SATURATE_EN
//   defined   -> counter is held at max, ovf is sticky until clear/rst
//   undefined -> counter wraps, ovf pulses together with the wrapping cnt_en
module bcd_stopwatch_ctrl #(
    parameter int PARAM_DIGITS = 4,
    parameter int PARAM_BASE   = 10,
    parameter int PARAM_DIV    = 4
) (
    input logic                clk,
    input logic                rst,
    bcd_stopwatch_ctrl_if.slave bus
);
    localparam int              PW         = (PARAM_DIV > 1) ? $clog2(PARAM_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(PARAM_DIV - 1);
    localparam logic [3:0]      DIGIT_MAX  = 4'(PARAM_BASE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        LAP   = 2'd3
    } state_t;

    state_t                    state_q;
    logic [PW-1:0]             presc_q;
    logic [4*PARAM_DIGITS-1:0] lap_q;
    logic                      clr_q;
    logic                      at_max;
    logic                      counting;
    logic                      tick;

    // All digits at their maximum; each digit is judged on its 4-bit field only.
    always_comb begin
        at_max = 1'b1;
        for (int i = 0; i < PARAM_DIGITS; i++) begin
            if (bus.cnt_data[4*i +: 4] != DIGIT_MAX) begin
                at_max = 1'b0;
            end
        end
    end

    // A tick is due on the last prescaler phase while the watch is counting.
    assign counting = (state_q == RUN) || (state_q == LAP);
    assign tick     = counting && (presc_q == PRESC_LAST);

`ifdef BCD_STOPWATCH_SATURATE_EN
    logic ovf_q;

    // Sticky overflow: set when a tick would have fired at max, held until clear/rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (bus.cmd_clear) begin
            ovf_q <= 1'b0;
        end else if (tick && at_max) begin
            ovf_q <= 1'b1;
        end
    end

    assign bus.cnt_en = tick && !at_max;
    assign bus.ovf    = ovf_q;
`else
    assign bus.cnt_en = tick;
    assign bus.ovf    = tick && at_max;
`endif

    // Command sequencing, prescaler, lap capture and registered counter clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            presc_q <= '0;
            lap_q   <= '0;
            clr_q   <= 1'b1;
        end else begin
            clr_q <= bus.cmd_clear;

            // The prescaler advances on every counting edge, including the one
            // that leaves RUN/LAP, so a pause keeps the phase reached so far.
            if (counting) begin
                presc_q <= (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
            end

            if (bus.cmd_clear) begin
                state_q <= IDLE;
                presc_q <= '0;
                lap_q   <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (bus.cmd_start_stop) begin
                            state_q <= RUN;
                            presc_q <= '0;
                        end
                    end
                    RUN: begin
                        if (bus.cmd_start_stop) begin
                            state_q <= PAUSE;
                        end else if (bus.cmd_lap) begin
                            state_q <= LAP;
                            lap_q   <= bus.cnt_data;
                        end
                    end
                    LAP: begin
                        if (bus.cmd_start_stop) begin
                            state_q <= PAUSE;
                        end else if (bus.cmd_lap) begin
                            state_q <= RUN;
                        end
                    end
                    PAUSE: begin
                        if (bus.cmd_start_stop) begin
                            state_q <= RUN;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.cnt_clr   = clr_q;
    assign bus.state     = state_q;
    assign bus.disp_data = (state_q == LAP) ? lap_q : bus.cnt_data;
endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// Directed bench for bcd_stopwatch_ctrl (DIGITS=4, BASE=10, DIV=4).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_bcd_stopwatch_ctrl;
    logic clk;
    logic rst;
    int   total;
    int   passed;

    bcd_stopwatch_ctrl_if #(.PARAM_DIGITS(4)) bus ();

    bcd_stopwatch_ctrl #(
        .PARAM_DIGITS(4),
        .PARAM_BASE  (10),
        .PARAM_DIV   (4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Clock and power-on values.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.cmd_start_stop = 1'b1;
        tick();
        bus.cmd_start_stop = 1'b0;
    endtask

    task automatic pulse_lap();
        bus.cmd_lap = 1'b1;
        tick();
        bus.cmd_lap = 1'b0;
    endtask

    task automatic pulse_clear();
        bus.cmd_clear = 1'b1;
        tick();
        bus.cmd_clear = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.cnt_data = 16'h1234;
        tick();
        tick();
        total++; if (bus.state !== 2'd0) $display("FAIL reset_state got %0d want 0", bus.state); else passed++;
        total++; if (bus.cnt_clr !== 1'b1) $display("FAIL reset_clr got %b want 1", bus.cnt_clr); else passed++;
        total++; if (bus.cnt_en !== 1'b0) $display("FAIL reset_en got %b want 0", bus.cnt_en); else passed++;
        total++; if (bus.ovf !== 1'b0) $display("FAIL reset_ovf got %b want 0", bus.ovf); else passed++;
        total++; if (bus.disp_data !== 16'h1234) $display("FAIL reset_disp got %h want 1234", bus.disp_data); else passed++;
        rst = 1'b0;
        tick();
        total++; if (bus.cnt_clr !== 1'b0) $display("FAIL post_reset_clr got %b want 0", bus.cnt_clr); else passed++;
        total++; if (bus.state !== 2'd0) $display("FAIL post_reset_state got %0d want 0", bus.state); else passed++;
    endtask

    task automatic test_run();
        logic exp_en;
        pulse_start();
        total++; if (bus.state !== 2'd1) $display("FAIL run_state got %0d want 1", bus.state); else passed++;
        total++; if (bus.cnt_en !== 1'b0) $display("FAIL run_en0 got %b want 0", bus.cnt_en); else passed++;
        for (int j = 1; j <= 12; j++) begin
            tick();
            exp_en = ((j % 4) == 3);
            total++;
            if (bus.cnt_en !== exp_en) $display("FAIL run_en_k%0d got %b want %b", j, bus.cnt_en, exp_en);
            else passed++;
        end
        pulse_start();
        total++; if (bus.state !== 2'd2) $display("FAIL pause_state got %0d want 2", bus.state); else passed++;
        for (int j = 0; j < 5; j++) begin
            total++;
            if (bus.cnt_en !== 1'b0) $display("FAIL pause_en cycle %0d got %b want 0", j, bus.cnt_en);
            else passed++;
            tick();
        end
    endtask

    task automatic test_resume();
        pulse_clear();
        total++; if (bus.cnt_clr !== 1'b1) $display("FAIL clear_clr got %b want 1", bus.cnt_clr); else passed++;
        total++; if (bus.state !== 2'd0) $display("FAIL clear_state got %0d want 0", bus.state); else passed++;
        tick();
        total++; if (bus.cnt_clr !== 1'b0) $display("FAIL clear_clr_drop got %b want 0", bus.cnt_clr); else passed++;
        pulse_start();          // prescaler 0
        tick();                 // prescaler 1
        pulse_start();          // prescaler 2, paused
        total++; if (bus.state !== 2'd2) $display("FAIL resume_pause_state got %0d want 2", bus.state); else passed++;
        for (int j = 0; j < 3; j++) begin
            tick();
            total++;
            if (bus.cnt_en !== 1'b0) $display("FAIL resume_hold_en cycle %0d got %b want 0", j, bus.cnt_en);
            else passed++;
        end
        pulse_start();          // back to RUN, prescaler still 2
        total++; if (bus.state !== 2'd1) $display("FAIL resume_state got %0d want 1", bus.state); else passed++;
        total++; if (bus.cnt_en !== 1'b0) $display("FAIL resume_en0 got %b want 0", bus.cnt_en); else passed++;
        tick();
        total++; if (bus.cnt_en !== 1'b1) $display("FAIL resume_en1 got %b want 1", bus.cnt_en); else passed++;
        tick();
        total++; if (bus.cnt_en !== 1'b0) $display("FAIL resume_en2 got %b want 0", bus.cnt_en); else passed++;
    endtask

    task automatic test_lap();
        pulse_clear();
        bus.cnt_data = 16'h0042;
        pulse_start();          // prescaler 0
        tick();                 // prescaler 1
        pulse_lap();            // prescaler 2, lap holds 0042
        total++; if (bus.state !== 2'd3) $display("FAIL lap_state got %0d want 3", bus.state); else passed++;
        total++; if (bus.disp_data !== 16'h0042) $display("FAIL lap_disp got %h want 0042", bus.disp_data); else passed++;
        bus.cnt_data = 16'h0043;
        #1;
        total++; if (bus.disp_data !== 16'h0042) $display("FAIL lap_frozen got %h want 0042", bus.disp_data); else passed++;
        tick();                 // prescaler 3
        total++; if (bus.cnt_en !== 1'b1) $display("FAIL lap_en got %b want 1", bus.cnt_en); else passed++;
        total++; if (bus.disp_data !== 16'h0042) $display("FAIL lap_frozen_tick got %h want 0042", bus.disp_data); else passed++;
        bus.cnt_data = 16'h0044;
        tick();                 // prescaler 0
        total++; if (bus.cnt_en !== 1'b0) $display("FAIL lap_en_off got %b want 0", bus.cnt_en); else passed++;
        pulse_lap();            // prescaler 1, back to RUN
        total++; if (bus.state !== 2'd1) $display("FAIL lap_release_state got %0d want 1", bus.state); else passed++;
        bus.cnt_data = 16'h0045;
        #1;
        total++; if (bus.disp_data !== 16'h0045) $display("FAIL lap_release_disp got %h want 0045", bus.disp_data); else passed++;
        pulse_lap();            // prescaler 2, lap holds 0045
        bus.cnt_data = 16'h0046;
        #1;
        total++; if (bus.disp_data !== 16'h0045) $display("FAIL lap2_disp got %h want 0045", bus.disp_data); else passed++;
        pulse_start();          // prescaler 3, LAP -> PAUSE
        total++; if (bus.state !== 2'd2) $display("FAIL lap_pause_state got %0d want 2", bus.state); else passed++;
        total++; if (bus.cnt_en !== 1'b0) $display("FAIL lap_pause_en got %b want 0", bus.cnt_en); else passed++;
        total++; if (bus.disp_data !== 16'h0046) $display("FAIL lap_pause_disp got %h want 0046", bus.disp_data); else passed++;
    endtask

    task automatic test_priority();
        pulse_start();          // resume at prescaler 3
        total++; if (bus.cnt_en !== 1'b1) $display("FAIL prio_resume_en got %b want 1", bus.cnt_en); else passed++;
        tick();                 // prescaler 0
        bus.cmd_clear = 1'b1;
        bus.cmd_start_stop = 1'b1;
        bus.cmd_lap = 1'b1;
        tick();
        bus.cmd_clear = 1'b0;
        bus.cmd_start_stop = 1'b0;
        bus.cmd_lap = 1'b0;
        total++; if (bus.state !== 2'd0) $display("FAIL prio_state got %0d want 0", bus.state); else passed++;
        total++; if (bus.cnt_clr !== 1'b1) $display("FAIL prio_clr got %b want 1", bus.cnt_clr); else passed++;
        total++; if (bus.cnt_en !== 1'b0) $display("FAIL prio_en got %b want 0", bus.cnt_en); else passed++;
        tick();
        total++; if (bus.cnt_clr !== 1'b0) $display("FAIL prio_clr_once got %b want 0", bus.cnt_clr); else passed++;
        total++; if (bus.state !== 2'd0) $display("FAIL prio_idle_hold got %0d want 0", bus.state); else passed++;
        pulse_start();
        tick();
        tick();
        total++; if (bus.cnt_en !== 1'b0) $display("FAIL prio_presc_early got %b want 0", bus.cnt_en); else passed++;
        tick();
        total++; if (bus.cnt_en !== 1'b1) $display("FAIL prio_presc_tick got %b want 1", bus.cnt_en); else passed++;
    endtask

    task automatic test_max();
        logic exp_en_k3;
        logic exp_ovf_k3;
        logic exp_ovf_k4;
        logic exp_ovf_k7;
`ifdef BCD_STOPWATCH_SATURATE_EN
        exp_en_k3 = 1'b0; exp_ovf_k3 = 1'b0; exp_ovf_k4 = 1'b1; exp_ovf_k7 = 1'b1;
`else
        exp_en_k3 = 1'b1; exp_ovf_k3 = 1'b1; exp_ovf_k4 = 1'b0; exp_ovf_k7 = 1'b0;
`endif
        pulse_clear();
        bus.cnt_data = 16'h9999;
        pulse_start();
        tick();
        tick();
        total++; if (bus.ovf !== 1'b0) $display("FAIL max_ovf_early got %b want 0", bus.ovf); else passed++;
        tick();
        total++; if (bus.cnt_en !== exp_en_k3) $display("FAIL max_en got %b want %b", bus.cnt_en, exp_en_k3); else passed++;
        total++; if (bus.ovf !== exp_ovf_k3) $display("FAIL max_ovf_tick got %b want %b", bus.ovf, exp_ovf_k3); else passed++;
        tick();
        total++; if (bus.cnt_en !== 1'b0) $display("FAIL max_en_after got %b want 0", bus.cnt_en); else passed++;
        total++; if (bus.ovf !== exp_ovf_k4) $display("FAIL max_ovf_after got %b want %b", bus.ovf, exp_ovf_k4); else passed++;
        bus.cnt_data = 16'h0000;
        tick();
        tick();
        tick();
        total++; if (bus.cnt_en !== 1'b1) $display("FAIL max_wrap_en got %b want 1", bus.cnt_en); else passed++;
        total++; if (bus.ovf !== exp_ovf_k7) $display("FAIL max_ovf_hold got %b want %b", bus.ovf, exp_ovf_k7); else passed++;
        total++; if (bus.state !== 2'd1) $display("FAIL max_state got %0d want 1", bus.state); else passed++;
        pulse_clear();
        total++; if (bus.ovf !== 1'b0) $display("FAIL max_ovf_clear got %b want 0", bus.ovf); else passed++;
    endtask

    task automatic test_reset_mid();
        bus.cnt_data = 16'h0123;
        pulse_start();
        pulse_lap();
        total++; if (bus.state !== 2'd3) $display("FAIL mid_lap_state got %0d want 3", bus.state); else passed++;
        bus.cnt_data = 16'h0124;
        rst = 1'b1;
        tick();
        total++; if (bus.state !== 2'd0) $display("FAIL mid_rst_state got %0d want 0", bus.state); else passed++;
        total++; if (bus.cnt_clr !== 1'b1) $display("FAIL mid_rst_clr got %b want 1", bus.cnt_clr); else passed++;
        total++; if (bus.disp_data !== 16'h0124) $display("FAIL mid_rst_disp got %h want 0124", bus.disp_data); else passed++;
        total++; if (bus.cnt_en !== 1'b0) $display("FAIL mid_rst_en got %b want 0", bus.cnt_en); else passed++;
        rst = 1'b0;
        tick();
        total++; if (bus.cnt_clr !== 1'b0) $display("FAIL mid_rst_clr_drop got %b want 0", bus.cnt_clr); else passed++;
    endtask

    // Test sequence and final report.
    initial begin
        total = 0;
        passed = 0;
        rst = 1'b1;
        bus.cmd_start_stop = 1'b0;
        bus.cmd_lap = 1'b0;
        bus.cmd_clear = 1'b0;
        bus.cnt_data = '0;
        test_reset();
        test_run();
        test_resume();
        test_lap();
        test_priority();
        test_max();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/bcd_stopwatch_ctrl.md
Name: bcd_stopwatch_ctrl

Overview:
- Sequencing controller for the team's N-digit BCD counter (enable-capable variant). Turns user commands (start/stop, lap, clear) into a prescaled count-enable and a synchronous counter clear.
- Provides a lap-freeze display mux and overflow signalling.
- Sits between the debounced pushbutton pulses and the counter/seven-segment display path.

Parameters:
- PARAM_DIGITS, 4, number of BCD digits on the counter; data width is 4*PARAM_DIGITS.
- PARAM_BASE, 10, per-digit modulus; the maximum digit value is PARAM_BASE-1.
- PARAM_DIV, 4, clocks per count tick; legal range is 1 or more.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_start_stop  in  1  one-cycle pulse that toggles between run and pause.
- cmd_lap  in  1  one-cycle pulse that freezes or releases the display.
- cmd_clear  in  1  one-cycle pulse that returns the block to idle and zeroes the counter.
- cnt_data  in  4*PARAM_DIGITS  live BCD value from the counter.
- cnt_en  out  1  count enable to the counter, one clock per tick.
- cnt_clr  out  1  synchronous clear to the counter.
- disp_data  out  4*PARAM_DIGITS  value to display.
- state  out  2  current state: IDLE=0, RUN=1, PAUSE=2, LAP=3.
- ovf  out  1  overflow indication.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE, prescaler=0, lap_reg=0, ovf=0.
  - cnt_clr=1 while rst is high; cnt_en=0.
- Prescaler:
  - Width $clog2(PARAM_DIV), minimum 1 bit.
  - Counts 0..PARAM_DIV-1 and wraps, only in RUN or LAP.
  - Holds its value in PAUSE; forced to 0 in IDLE.
- cnt_en:
  - Combinational: (state is RUN or LAP) AND prescaler==PARAM_DIV-1.
  - With PARAM_DIV=1, cnt_en is high on every RUN/LAP cycle.
- Command priority when several commands arrive in the same cycle: clear > start_stop > lap. Lower-priority commands in that cycle are dropped.
- State transitions (taken at the edge that samples the command):
  - IDLE: start_stop goes to RUN with prescaler=0; lap is ignored; clear stays in IDLE.
  - RUN: start_stop goes to PAUSE; lap goes to LAP and captures lap_reg<=cnt_data at that edge; clear goes to IDLE.
  - LAP: start_stop goes to PAUSE and the display becomes live again; lap goes to RUN; clear goes to IDLE. Counting continues throughout LAP.
  - PAUSE: start_stop goes to RUN and the prescaler resumes from its held value; lap is ignored; clear goes to IDLE.
- cnt_clr:
  - Registered; high for exactly one cycle after the edge that samples cmd_clear, in any state.
  - The same clear also sets prescaler=0, lap_reg=0 and ovf=0.
- Display:
  - disp_data = lap_reg when state==LAP, otherwise cnt_data.
  - Combinational mux of registered or input values; zero added latency.
- Start-to-tick latency: with start sampled at edge k, the first cnt_en is high in the cycle following edge k+PARAM_DIV-1.
- Max detection:
  - at_max is true when every digit of cnt_data equals PARAM_BASE-1.
  - Digits are compared as 4-bit fields; upper bits are don't-care if the counter drives them beyond the digit range.
- Reset mid-operation: rst overrides everything and takes effect at the next edge, including mid-tick and during LAP.

Optional Feature:
- Macro: BCD_STOPWATCH_SATURATE_EN.
- Defined (saturating):
  - cnt_en is gated off whenever at_max is true, so the counter holds at max.
  - ovf is set at the first edge where a tick would have fired while at_max.
  - ovf is sticky until clear or rst; state is unchanged.
- Undefined (wrapping):
  - cnt_en is not gated, so the counter wraps to 0.
  - ovf is a one-cycle pulse, coincident with cnt_en, whenever at_max && cnt_en; ovf is not sticky.

Test Plan (PARAM_DIGITS=4, PARAM_BASE=10, PARAM_DIV=4):
- rst high for 2 cycles, then low → state=0, cnt_clr=1 during rst, cnt_en=0, disp_data=cnt_data, ovf=0.
- start pulse at edge k → state=1; cnt_en high only in the cycles after edges k+3, k+7, k+11…; then another start → state=2 and cnt_en stays 0.
- Resume after pausing at prescaler=2 → the first cnt_en arrives 1 cycle after resume (the prescaler kept its value).
- RUN with cnt_data=16'h0042, lap pulse → state=3, disp_data=16'h0042 while cnt_data advances and cnt_en keeps pulsing; second lap → state=1 and disp_data tracks cnt_data.
- clear, start_stop and lap all asserted together in RUN → state=0, cnt_clr high for exactly 1 cycle, lap_reg=0, prescaler=0.
- cnt_data forced to 16'h9999 in RUN:
  - With the macro: cnt_en stays 0 and ovf rises and sticks until clear.
  - Without the macro: ovf pulses for 1 cycle together with cnt_en.
